// File: rtl/spw_tx_credit_sched_pkg.sv
// Shared state encoding and credit constants for the SpaceWire TX credit scheduler.
package spw_tx_credit_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_TCODE = 3'd4
  } state_t;

  localparam int SPW_CREDIT_STEP = 8;
  localparam int SPW_CREDIT_MAX  = 56;
  localparam int CTRL_BIT        = 8;

endpackage

// File: rtl/spw_credit_counter.sv
// Outstanding FCT credit: add a step per FCT, subtract one per latched N-char, flag overflow.
module spw_credit_counter
  import spw_tx_credit_sched_pkg::*;
#(
  parameter int CWIDTH      = 6,
  parameter int CREDIT_STEP = SPW_CREDIT_STEP,
  parameter int CREDIT_MAX  = SPW_CREDIT_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              fct,
  input  logic              dec,
  output logic [CWIDTH-1:0] credit,
  output logic              credit_error
);

  localparam int SW = CWIDTH + 2;

  logic [SW-1:0] base;
  logic [SW-1:0] next_sum;
  logic          overflow;

  // Two guard bits keep credit + step from wrapping before the limit compare.
  always_comb begin
    base     = {2'b00, credit} - SW'(dec);
    next_sum = base + (fct ? SW'(CREDIT_STEP) : '0);
    overflow = fct && (next_sum > SW'(CREDIT_MAX));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit       <= '0;
      credit_error <= 1'b0;
    end else if (clear) begin
      credit       <= '0;
      credit_error <= 1'b0;
    end else begin
      credit_error <= overflow;
      credit       <= overflow ? base[CWIDTH-1:0] : next_sum[CWIDTH-1:0];
    end
  end

endmodule

// File: rtl/spw_tx_credit_sched.sv
// Pops the TX FIFO under FCT credit and offers N-chars and time-codes to the encoder.
// Defining SPW_TX_STATS_EN adds the nchar_count/eop_count statistics outputs.
module spw_tx_credit_sched
  import spw_tx_credit_sched_pkg::*;
#(
  parameter int DWIDTH      = 9,
  parameter int CWIDTH      = 6,
  parameter int CREDIT_STEP = SPW_CREDIT_STEP,
  parameter int CREDIT_MAX  = SPW_CREDIT_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_run,
  input  logic              got_fct,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              tick_in,
  input  logic [7:0]        time_in,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tc_valid,
  output logic [7:0]        tc_data,
  output logic [CWIDTH-1:0] credit,
  output logic              credit_error
`ifdef SPW_TX_STATS_EN
  ,
  output logic [15:0]       nchar_count,
  output logic [15:0]       eop_count
`endif
);

  state_t     state;
  logic       tc_pending;
  logic [7:0] tc_value;

  spw_credit_counter #(
    .CWIDTH      (CWIDTH),
    .CREDIT_STEP (CREDIT_STEP),
    .CREDIT_MAX  (CREDIT_MAX)
  ) u_credit (
    .clock        (clock),
    .reset        (reset),
    .clear        (!link_run),
    .fct          (got_fct),
    .dec          (state == S_LATCH),
    .credit       (credit),
    .credit_error (credit_error)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tc_valid   <= 1'b0;
      tc_data    <= '0;
      tc_pending <= 1'b0;
      tc_value   <= '0;
    end else if (!link_run) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      tx_valid   <= 1'b0;
      tc_valid   <= 1'b0;
      tc_pending <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      if (tick_in) begin
        tc_pending <= 1'b1;
        tc_value   <= time_in;
      end
      case (state)
        S_IDLE: begin
          if (tc_pending) begin
            // A tick arriving this same cycle is the newest value, so send it.
            state    <= S_TCODE;
            tc_valid <= 1'b1;
            tc_data  <= tick_in ? time_in : tc_value;
          end else if (!fifo_empty && (credit != '0)) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          tx_data  <= fifo_data;
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_TCODE: begin
          if (tx_ready) begin
            tc_valid <= 1'b0;
            state    <= S_IDLE;
            if (!tick_in) tc_pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPW_TX_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nchar_count <= '0;
      eop_count   <= '0;
    end else if (link_run && (state == S_SEND) && tx_ready) begin
      nchar_count <= nchar_count + 16'd1;
      if (tx_data[CTRL_BIT]) eop_count <= eop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spw_tx_credit_sched.sv
// Bench for spw_tx_credit_sched: directed scenarios plus random traffic against a transaction model.
module tb_spw_tx_credit_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       link_run = 1'b0;
  logic       got_fct = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [8:0] fifo_data = '0;
  logic       tick_in = 1'b0;
  logic [7:0] time_in = '0;
  logic       tx_ready = 1'b0;
  logic       fifo_rd_en, tx_valid, tc_valid, credit_error;
  logic [8:0] tx_data;
  logic [7:0] tc_data;
  logic [5:0] credit;
`ifdef SPW_TX_STATS_EN
  logic [15:0] nchar_count, eop_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] fifo_q[$];
  bit         prev_rd;

  // Transaction model: age of the N-char in flight (-1 none, 0 popping, 1 latching, 2 offered).
  int         m_age, m_credit, m_nchar, m_eop;
  bit         m_tc_offer, m_pending, m_err;
  logic [7:0] m_tval, m_tcd;
  logic [8:0] m_txd;

  spw_tx_credit_sched dut (
    .clock        (clock),
    .reset        (reset),
    .link_run     (link_run),
    .got_fct      (got_fct),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .tick_in      (tick_in),
    .time_in      (time_in),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tc_valid     (tc_valid),
    .tc_data      (tc_data),
    .credit       (credit),
    .credit_error (credit_error)
`ifdef SPW_TX_STATS_EN
    ,
    .nchar_count  (nchar_count),
    .eop_count    (eop_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_age = -1; m_credit = 0; m_tc_offer = 0; m_pending = 0; m_err = 0;
    m_tval = '0; m_tcd = '0; m_txd = '0; m_nchar = 0; m_eop = 0;
  endtask

  task automatic model_step();
    int c;
    bit latch;
    if (!reset) begin model_clear(); return; end
    if (!link_run) begin
      m_age = -1; m_tc_offer = 0; m_pending = 0; m_credit = 0; m_err = 0;
      return;
    end
    latch = (m_age == 1);
    c = m_credit + (got_fct ? 8 : 0) - (latch ? 1 : 0);
    m_err = got_fct && (c > 56);
    if (m_err) c = m_credit - (latch ? 1 : 0);
    if (m_tc_offer) begin
      if (tx_ready) begin m_tc_offer = 0; m_pending = 0; end
    end else if (m_age >= 2) begin
      if (tx_ready) begin
        m_age = -1;
        m_nchar++;
        if (m_txd[8]) m_eop++;
      end
    end else if (m_age >= 0) begin
      if (latch) m_txd = fifo_data;
      m_age++;
    end else if (m_pending) begin
      m_tc_offer = 1;
      m_tcd = tick_in ? time_in : m_tval;
    end else if (!fifo_empty && m_credit > 0) begin
      m_age = 0;
    end
    if (tick_in) begin m_pending = 1; m_tval = time_in; end
    m_credit = c;
  endtask

  task automatic compare();
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(m_age == 0));
    check("tx_valid", 32'(tx_valid), 32'(m_age == 2));
    check("tc_valid", 32'(tc_valid), 32'(m_tc_offer));
    check("credit", 32'(credit), m_credit);
    check("credit_error", 32'(credit_error), 32'(m_err));
    if (m_age == 2) check("tx_data", 32'(tx_data), 32'(m_txd));
    if (m_tc_offer) check("tc_data", 32'(tc_data), 32'(m_tcd));
`ifdef SPW_TX_STATS_EN
    check("nchar_count", 32'(nchar_count), m_nchar % 65536);
    check("eop_count", 32'(eop_count), m_eop % 65536);
`endif
  endtask

  task automatic step();
    model_step();
    prev_rd = fifo_rd_en;
    @(posedge clock);
    @(negedge clock);
    got_fct = 1'b0;
    tick_in = 1'b0;
    if (prev_rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    compare();
  endtask

  task automatic push(input logic [8:0] v);
    fifo_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic abort_link();
    link_run = 1'b0; step();
    link_run = 1'b1; step();
  endtask

  task automatic step_until_txv(input int budget);
    int n = 0;
    while (tx_valid !== 1'b1 && n < budget) begin step(); n++; end
    check("wait tx_valid", 32'(tx_valid), 32'd1);
  endtask

  task automatic pop_within(input string name, input int budget);
    int n = 0;
    while (fifo_rd_en !== 1'b1 && n < budget) begin step(); n++; end
    check(name, 32'(fifo_rd_en), 32'd1);
  endtask

  initial begin
    logic [8:0] t1_chars[5];
    logic [8:0] seen[$];
    int nrd;
    t1_chars = '{9'h041, 9'h042, 9'h143, 9'h044, 9'h100};
    model_clear();

    // Reset values
    @(negedge clock);
    check("rst rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst tc_valid", 32'(tc_valid), 32'd0);
    check("rst credit", 32'(credit), 32'd0);
    check("rst credit_error", 32'(credit_error), 32'd0);
    reset = 1'b1; link_run = 1'b1; tx_ready = 1'b1;
    step();

    // Three FCTs, then five chars drained in order
    repeat (3) begin got_fct = 1'b1; step(); end
    check("t1 credit 24", 32'(credit), 32'd24);
    foreach (t1_chars[i]) push(t1_chars[i]);
    nrd = 0;
    repeat (30) begin
      step();
      if (fifo_rd_en) nrd++;
      if (tx_valid && tx_ready) seen.push_back(tx_data);
    end
    check("t1 pops", 32'(nrd), 32'd5);
    check("t1 credit 19", 32'(credit), 32'd19);
    check("t1 sent count", 32'(seen.size()), 32'd5);
    foreach (seen[i]) if (i < 5) check("t1 order", 32'(seen[i]), 32'(t1_chars[i]));

    // No credit: FIFO must not be read
    abort_link();
    push(9'h011); push(9'h012); push(9'h013);
    nrd = 0;
    repeat (100) begin step(); if (fifo_rd_en) nrd++; end
    check("t2 no pop", 32'(nrd), 32'd0);
    got_fct = 1'b1; step();
    pop_within("t2 first pop", 1);
    repeat (20) step();

    // Credit saturation
    abort_link();
    repeat (7) begin got_fct = 1'b1; step(); end
    check("t3 credit 56", 32'(credit), 32'd56);
    got_fct = 1'b1; step();
    check("t3 overflow err", 32'(credit_error), 32'd1);
    check("t3 credit held", 32'(credit), 32'd56);
    step();
    check("t3 err one cycle", 32'(credit_error), 32'd0);

    // Time-code waits behind an N-char stalled in SEND
    tx_ready = 1'b0;
    push(9'h0A5);
    step_until_txv(10);
    tick_in = 1'b1; time_in = 8'h2A; step();
    repeat (3) step();
    check("t4 tc held off", 32'(tc_valid), 32'd0);
    check("t4 char still offered", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1; step();
    check("t4 char accepted", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0; step();
    check("t4 tc_valid", 32'(tc_valid), 32'd1);
    check("t4 tc_data", 32'(tc_data), 32'h2A);
    tx_ready = 1'b1; step();
    check("t4 tc done", 32'(tc_valid), 32'd0);

    // FCT coincident with LATCH at credit 3
    abort_link();
    got_fct = 1'b1; step();
    repeat (5) push(9'($urandom));
    repeat (30) step();
    check("t5 credit 3", 32'(credit), 32'd3);
    push(9'h077);
    pop_within("t5 pop", 3);
    step();
    got_fct = 1'b1; step();
    check("t5 credit 10", 32'(credit), 32'd10);
    repeat (5) step();

    // Link abort during SEND
    tx_ready = 1'b0;
    push(9'h155);
    step_until_txv(10);
    link_run = 1'b0; step();
    check("t6 tx_valid low", 32'(tx_valid), 32'd0);
    check("t6 credit 0", 32'(credit), 32'd0);
    link_run = 1'b1;
    push(9'h021); push(9'h122);
    nrd = 0;
    repeat (10) begin step(); if (fifo_rd_en) nrd++; end
    check("t6 no pop", 32'(nrd), 32'd0);
    got_fct = 1'b1; step();
    pop_within("t6 pop after fct", 1);
    tx_ready = 1'b1;
    repeat (20) step();

    // Asynchronous reset in SEND
    tx_ready = 1'b0;
    push(9'h0F0);
    step_until_txv(10);
    reset = 1'b0;
    #1;
    check("t7 async tx_valid", 32'(tx_valid), 32'd0);
    check("t7 async credit", 32'(credit), 32'd0);
    model_clear();
    step();
    reset = 1'b1;
    step();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      link_run = ($urandom_range(0, 199) != 0);
      got_fct  = ($urandom_range(0, 9) == 0);
      tick_in  = ($urandom_range(0, 24) == 0);
      time_in  = 8'($urandom);
      tx_ready = ($urandom_range(0, 1) == 1);
      if (fifo_q.size() < 16 && $urandom_range(0, 2) == 0) push(9'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
